muldiv_seq: RTL

Iterative multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU in the EX stage. It accepts one operation and its operands, then runs 32 shift-add or restore-subtract iterations. It applies sign correction and RV32M corner-case rules, and holds the result for one done cycle. While it works, it drives a stall that freezes the pipeline in front of EX.

---
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// One operation is accepted at a time. XLEN shift-add or restoring-divide
// iterations follow, then one fixup cycle and one done cycle.
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | XLEN iterations, one bit per cycle
//   FIX   | sign correction and corner overrides, result loaded
//   DONE  | done high for one cycle, result valid
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      func3_q;
  logic            neg_q, div0_q, ovf_q;
  logic [XLEN-1:0] acc_q, lo_q, opb_q, result_q;
  logic            busy_q, done_q;

  logic            is_mul, sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            neg_init, div0_init, ovf_init;
  logic [XLEN-1:0] opb_init, lo_init;
  logic [XLEN:0]   mul_sum, div_sh;
  logic            div_ge;
  logic [XLEN-1:0] acc_d, lo_d;
  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0] quo, rem, res_d;

  // Accept-time operand conditioning, one iteration step, and fixup result.
  always_comb begin
    is_mul = ~func3[2];
    sgn1   = is_mul ? (func3 != 3'b011) : ~func3[0];
    sgn2   = is_mul ? ~func3[1] : ~func3[0];
    neg1   = sgn1 & in1[XLEN-1];
    neg2   = sgn2 & in2[XLEN-1];
    mag1   = neg1 ? -in1 : in1;
    mag2   = neg2 ? -in2 : in2;
    // Remainder follows the dividend; products and quotients follow the sign xor.
    neg_init  = (is_mul || !func3[1]) ? (neg1 ^ neg2) : neg1;
    div0_init = (in2 == '0);
    ovf_init  = func3[2] & ~func3[0] & (in1 == INT_MIN) & (in2 == '1);
    // Multiply keeps the multiplier in lo and shifts it out LSB first;
    // divide keeps the dividend in lo and shifts it out MSB first.
    opb_init  = is_mul ? mag1 : mag2;
    lo_init   = is_mul ? mag2 : mag1;

    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh  = {acc_q, lo_q[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, opb_q});
    if (func3_q[2]) begin
      // A successful subtract leaves a remainder below the divisor, so XLEN bits suffice.
      acc_d = div_ge ? (div_sh[XLEN-1:0] - opb_q) : div_sh[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod_raw = {acc_q, lo_q};
    prod     = neg_q ? -prod_raw : prod_raw;
    quo      = neg_q ? -lo_q : lo_q;
    rem      = neg_q ? -acc_q : acc_q;
    case (func3_q)
      3'b000:                 res_d = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_d = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_d = div0_q ? '1 : (ovf_q ? INT_MIN : quo);
      // With a zero divisor every subtract succeeds and the remainder is the
      // dividend magnitude, so the signed remainder already equals in1.
      default:                res_d = ovf_q ? '0 : rem;
    endcase
  end

  // Sequencer state, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            func3_q <= func3;
            neg_q   <= neg_init;
            div0_q  <= div0_init;
            ovf_q   <= ovf_init;
            opb_q   <= opb_init;
            lo_q    <= lo_init;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CALC;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= res_d;
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = (start & ((state_q == S_IDLE) | (state_q == S_DONE)) & ~flush) | busy_q;

endmodule
